// File: rtl/bus_arbiter_pkg.sv
// Shared types for the round-robin bus arbiter.
//   trans_e     : bus transfer type driven by the address-phase owner
//   arb_state_e : arbiter FSM state (parked on the default master / owned)
//   HoldW       : width of the per-owner NONSEQ hold counter
package bus_arbiter_pkg;

   // Bus transfer type, same encoding as the system bus.
   typedef enum logic [1:0] {
      TransIdle   = 2'b00,
      TransBusy   = 2'b01,
      TransNonseq = 2'b10,
      TransSeq    = 2'b11
   } trans_e;

   typedef enum logic [0:0] {
      StPark  = 1'b0,
      StOwned = 1'b1
   } arb_state_e;

   localparam int unsigned HoldW = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration handshake bundle between the bus masters and the arbiter.
//   req_i      : per-master bus request
//   trans_i    : transfer type of the current address-phase owner
//   ready_i    : bus ready from the selected slave
//   lock_i     : per-master locked-sequence request (only with BUS_ARB_LOCK_EN)
//   grant_o    : one-hot grant
//   addr_sel_o : address-phase owner index
//   data_sel_o : data-phase owner index
// Modports: slave = arbiter side, master = requester side.
interface bus_arbiter_if #(
   parameter int unsigned NumMasters = 4
);
   import bus_arbiter_pkg::*;

   localparam int unsigned IdxW = $clog2(NumMasters);

   logic [NumMasters-1:0] req_i;
   trans_e                trans_i;
   logic                  ready_i;
`ifdef BUS_ARB_LOCK_EN
   logic [NumMasters-1:0] lock_i;
`endif
   logic [NumMasters-1:0] grant_o;
   logic [IdxW-1:0]       addr_sel_o;
   logic [IdxW-1:0]       data_sel_o;

   modport slave (
`ifdef BUS_ARB_LOCK_EN
      input  lock_i,
`endif
      input  req_i,
      input  trans_i,
      input  ready_i,
      output grant_o,
      output addr_sel_o,
      output data_sel_o
   );

   modport master (
`ifdef BUS_ARB_LOCK_EN
      output lock_i,
`endif
      output req_i,
      output trans_i,
      output ready_i,
      input  grant_o,
      input  addr_sel_o,
      input  data_sel_o
   );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   last_i  : index of the last owner (lowest priority)
//   gnt_o   : one-hot pick
//   idx_o   : index of the pick
//   valid_o : at least one request present
// Scans last+1, last+2, ... with wrap-around, so last_i is only picked when it
// is the sole requester.
module bus_arbiter_rr_picker #(
   parameter int unsigned NumMasters = 4,
   localparam int unsigned IdxW = $clog2(NumMasters)
) (
   input  logic [NumMasters-1:0] req_i,
   input  logic [IdxW-1:0]       last_i,
   output logic [NumMasters-1:0] gnt_o,
   output logic [IdxW-1:0]       idx_o,
   output logic                  valid_o
);

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned i = 1; i <= NumMasters; i++) begin
         logic [IdxW-1:0] cand;
         cand = IdxW'((32'(last_i) + i) % NumMasters);
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter sharing the system bus among NumMasters masters.
// Registers a one-hot grant, the address-phase owner index and the data-phase
// owner index; re-arbitrates only at transfer boundaries.
//   clk_i  : bus clock
//   rst_ni : asynchronous active-low reset
//   bus_io : bus_arbiter_if.slave (req/trans/ready[/lock] in, grant/selects out)
// Optional feature macro: BUS_ARB_LOCK_EN adds lock_i; a locked owner keeps the
// bus regardless of request or hold quota.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned NumMasters    = 4,
   parameter int unsigned MaxHold       = 8,
   parameter int unsigned DefaultMaster = 0
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   bus_arbiter_if.slave  bus_io
);

   localparam int unsigned IdxW = $clog2(NumMasters);

   localparam logic [NumMasters-1:0] DefGrant = NumMasters'(1) << DefaultMaster;
   localparam logic [IdxW-1:0]       DefIdx   = IdxW'(DefaultMaster);
   localparam logic [HoldW-1:0]      MaxHoldC = HoldW'(MaxHold);

   arb_state_e            state_q, state_d;
   logic [NumMasters-1:0] grant_q, grant_d;
   logic [IdxW-1:0]       addr_sel_q, addr_sel_d;
   logic [IdxW-1:0]       data_sel_q, data_sel_d;
   logic [HoldW-1:0]      hold_q, hold_d;

   logic [NumMasters-1:0] owner_oh;
   logic                  others_req;
   logic                  lock_owner;
   logic                  is_idle, is_nonseq;
   logic [HoldW-1:0]      hold_next;
   logic                  quota_exh;
   logic                  eff_req;
   logic                  handover;

   logic [NumMasters-1:0] pick_oh;
   logic [IdxW-1:0]       pick_idx;
   logic                  pick_vld;

   // ---------------------------------------------------------------------------
   // Owner status
   // ---------------------------------------------------------------------------
   assign owner_oh   = NumMasters'(1) << addr_sel_q;
   assign others_req = |(bus_io.req_i & ~owner_oh);
   assign is_idle    = (bus_io.trans_i == TransIdle);
   assign is_nonseq  = (bus_io.trans_i == TransNonseq);

`ifdef BUS_ARB_LOCK_EN
   assign lock_owner = (state_q == StOwned) && bus_io.lock_i[addr_sel_q];
`else
   assign lock_owner = 1'b0;
`endif

   // Count including the NONSEQ accepted this cycle, so the owner issues at most
   // MaxHold NONSEQs while others wait and the last of them is the handover point.
   always_comb begin
      hold_next = hold_q;
      if (bus_io.ready_i && is_nonseq && (hold_q != MaxHoldC)) begin
         hold_next = hold_q + 1'b1;
      end
   end

   assign quota_exh = (hold_next == MaxHoldC) && others_req && !lock_owner;
   assign eff_req   = bus_io.req_i[addr_sel_q] && !quota_exh;

   // BUSY/SEQ and ready low never qualify, so bursts are never split.
   assign handover = bus_io.ready_i && !lock_owner && (is_idle || (is_nonseq && !eff_req));

   // ---------------------------------------------------------------------------
   // Round-robin pick; in park addr_sel_q is DefaultMaster so the scan starts
   // after it.
   // ---------------------------------------------------------------------------
   bus_arbiter_rr_picker #(
      .NumMasters (NumMasters)
   ) u_rr_picker (
      .req_i   (bus_io.req_i),
      .last_i  (addr_sel_q),
      .gnt_o   (pick_oh),
      .idx_o   (pick_idx),
      .valid_o (pick_vld)
   );

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      addr_sel_d = addr_sel_q;
      unique case (state_q)
         StPark: begin
            if (bus_io.ready_i && pick_vld) begin
               state_d    = StOwned;
               grant_d    = pick_oh;
               addr_sel_d = pick_idx;
            end
         end
         StOwned: begin
            if (handover) begin
               if (pick_vld) begin
                  grant_d    = pick_oh;
                  addr_sel_d = pick_idx;
               end else begin
                  state_d    = StPark;
                  grant_d    = DefGrant;
                  addr_sel_d = DefIdx;
               end
            end
         end
         default: begin
            state_d    = StPark;
            grant_d    = DefGrant;
            addr_sel_d = DefIdx;
         end
      endcase
   end

   // Data phase belongs to the previously accepted address phase.
   assign data_sel_d = bus_io.ready_i ? addr_sel_q : data_sel_q;

   assign hold_d = (grant_d != grant_q) ? '0 : hold_next;

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StPark;
         grant_q    <= DefGrant;
         addr_sel_q <= DefIdx;
         data_sel_q <= DefIdx;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         addr_sel_q <= addr_sel_d;
         data_sel_q <= data_sel_d;
         hold_q     <= hold_d;
      end
   end

   assign bus_io.grant_o    = grant_q;
   assign bus_io.addr_sel_o = addr_sel_q;
   assign bus_io.data_sel_o = data_sel_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (NumMasters=4, MaxHold=8, DefaultMaster=0).
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   typedef struct packed {
      logic [3:0] req;
      trans_e     trans;
      logic       ready;
      logic [3:0] grant;
      logic [1:0] addr;
      logic [1:0] data;
   } vec_t;

   localparam int NumVec = 18;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   vec_t vecs [NumVec];

   bus_arbiter_if #(.NumMasters(4)) bus ();

   bus_arbiter #(
      .NumMasters    (4),
      .MaxHold       (8),
      .DefaultMaster (0)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ea,
                        input logic [1:0] ed);
      tests++;
      if (bus.grant_o !== eg || bus.addr_sel_o !== ea || bus.data_sel_o !== ed) begin
         fails++;
         $display("FAIL %s: got grant=%b addr_sel=%0d data_sel=%0d, want grant=%b addr_sel=%0d data_sel=%0d",
                  name, bus.grant_o, bus.addr_sel_o, bus.data_sel_o, eg, ea, ed);
      end
   endtask

   // Apply inputs, advance one clock, leave time 1 after the edge.
   task automatic cyc(input logic [3:0] req, input trans_e trans, input logic ready);
      bus.req_i   = req;
      bus.trans_i = trans;
      bus.ready_i = ready;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;

      // Each row: inputs for one cycle, outputs expected after that edge.
      vecs[0]  = '{4'b0110, TransIdle,   1'b1, 4'b0010, 2'd1, 2'd0}; // park -> master 1
      vecs[1]  = '{4'b0100, TransNonseq, 1'b1, 4'b0100, 2'd2, 2'd1}; // m1 drops req on NONSEQ
      vecs[2]  = '{4'b1100, TransNonseq, 1'b1, 4'b0100, 2'd2, 2'd2}; // m2 burst beat 1
      vecs[3]  = '{4'b1100, TransSeq,    1'b0, 4'b0100, 2'd2, 2'd2}; // wait state
      vecs[4]  = '{4'b1100, TransSeq,    1'b1, 4'b0100, 2'd2, 2'd2}; // beat 2
      vecs[5]  = '{4'b1100, TransSeq,    1'b0, 4'b0100, 2'd2, 2'd2}; // wait state
      vecs[6]  = '{4'b1100, TransSeq,    1'b1, 4'b0100, 2'd2, 2'd2}; // beat 3
      vecs[7]  = '{4'b1000, TransSeq,    1'b1, 4'b0100, 2'd2, 2'd2}; // beat 4, m2 req dropped
      vecs[8]  = '{4'b1000, TransIdle,   1'b1, 4'b1000, 2'd3, 2'd2}; // IDLE -> master 3
      vecs[9]  = '{4'b1000, TransIdle,   1'b0, 4'b1000, 2'd3, 2'd2}; // ready low: hold
      vecs[10] = '{4'b0000, TransIdle,   1'b1, 4'b0001, 2'd0, 2'd3}; // nobody -> park
      vecs[11] = '{4'b0000, TransIdle,   1'b1, 4'b0001, 2'd0, 2'd0}; // stay parked
      vecs[12] = '{4'b0001, TransIdle,   1'b0, 4'b0001, 2'd0, 2'd0}; // req, ready low
      vecs[13] = '{4'b0001, TransIdle,   1'b1, 4'b0001, 2'd0, 2'd0}; // m0 sole -> owns
      vecs[14] = '{4'b1001, TransBusy,   1'b1, 4'b0001, 2'd0, 2'd0}; // BUSY: no handover
      vecs[15] = '{4'b1001, TransIdle,   1'b1, 4'b1000, 2'd3, 2'd0}; // rr -> master 3
      vecs[16] = '{4'b1001, TransIdle,   1'b1, 4'b0001, 2'd0, 2'd3}; // rr wraps -> master 0
      vecs[17] = '{4'b0001, TransIdle,   1'b1, 4'b0001, 2'd0, 2'd0}; // sole owner keeps it

      rst_n       = 1'b0;
      bus.req_i   = '0;
      bus.trans_i = TransIdle;
      bus.ready_i = 1'b0;
`ifdef BUS_ARB_LOCK_EN
      bus.lock_i  = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 4'b0001, 2'd0, 2'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cyc(4'b0000, TransIdle, 1'b1);
         check($sformatf("idle_%0d", i), 4'b0001, 2'd0, 2'd0);
      end

      for (int i = 0; i < NumVec; i++) begin
         cyc(vecs[i].req, vecs[i].trans, vecs[i].ready);
         check($sformatf("vec_%0d", i), vecs[i].grant, vecs[i].addr, vecs[i].data);
      end

      // Hold quota: m0 streams NONSEQ while m3 waits; the 8th accepted NONSEQ
      // is the handover point. A ready-low cycle in the middle is not counted.
      for (int k = 1; k <= 8; k++) begin
         cyc(4'b1001, TransNonseq, 1'b1);
         if (k < 8) check($sformatf("hold_%0d", k), 4'b0001, 2'd0, 2'd0);
         else       check("hold_expire", 4'b1000, 2'd3, 2'd0);
         if (k == 4) begin
            cyc(4'b1001, TransNonseq, 1'b0);
            check("hold_wait", 4'b0001, 2'd0, 2'd0);
         end
      end
      cyc(4'b1000, TransIdle, 1'b0);
      check("hold_data_wait", 4'b1000, 2'd3, 2'd0);
      cyc(4'b1000, TransIdle, 1'b1);
      check("hold_data_follow", 4'b1000, 2'd3, 2'd3);

      // Asynchronous reset in the middle of a master-2 burst.
      cyc(4'b0100, TransIdle, 1'b1);
      check("rst_pre_grant", 4'b0100, 2'd2, 2'd3);
      cyc(4'b0100, TransNonseq, 1'b1);
      check("rst_pre_nonseq", 4'b0100, 2'd2, 2'd2);
      cyc(4'b0100, TransSeq, 1'b1);
      check("rst_pre_seq", 4'b0100, 2'd2, 2'd2);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_async", 4'b0001, 2'd0, 2'd0);
      bus.req_i   = '0;
      bus.trans_i = TransIdle;
      #2;
      rst_n = 1'b1;
      cyc(4'b0000, TransIdle, 1'b1);
      check("rst_parked", 4'b0001, 2'd0, 2'd0);
      cyc(4'b0010, TransIdle, 1'b1);
      check("rst_regrant", 4'b0010, 2'd1, 2'd0);

`ifdef BUS_ARB_LOCK_EN
      // Locked owner keeps the bus past quota and against other requests.
      bus.lock_i = 4'b0010;
      for (int k = 0; k < 20; k++) begin
         cyc(4'b1111, TransNonseq, 1'b1);
         check($sformatf("lock_%0d", k), 4'b0010, 2'd1, 2'd1);
      end
      bus.lock_i = 4'b0000;
      cyc(4'b1111, TransSeq, 1'b1);
      check("unlock_seq", 4'b0010, 2'd1, 2'd1);
      cyc(4'b1111, TransIdle, 1'b1);
      check("unlock_idle", 4'b0100, 2'd2, 2'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
